// File: rtl/alu_sequencer.sv
// Accumulator micro-sequencer: queues opcode/operand commands and drives an external
// registered 8-bit ALU, including a shift-add 8x8 multiply (low byte) on that ALU.
module alu_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_opcode,
  input  logic [7:0] in_operand,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_y,
  output logic [7:0] acc,
  output logic       zero,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b010;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] arg;
  } cmd_t;

  typedef enum logic [3:0] {
    S_IDLE, S_EXEC, S_WB, S_LOAD, S_ILL,
    S_M_CHK, S_M_ADD, S_M_ADDWB, S_M_SHL, S_M_SHLWB
  } state_t;

  state_t state, state_d;

  // Command FIFO: extra pointer bit distinguishes full from empty.
  cmd_t          mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  cmd_t          head;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state == S_IDLE) && !empty;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cmd_t'{op: in_opcode, arg: in_operand};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  logic [2:0] cmd_op, cmd_op_d;
  logic [7:0] cmd_arg, cmd_arg_d;
  logic [7:0] acc_d, p, p_d, m, m_d, q, q_d;
  logic       done_d, err_d;
  logic [7:0] alu_a_d, alu_b_d;
  logic [2:0] alu_op_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cmd_op  <= '0;
      cmd_arg <= '0;
      acc     <= '0;
      p       <= '0;
      m       <= '0;
      q       <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
    end else begin
      state   <= state_d;
      cmd_op  <= cmd_op_d;
      cmd_arg <= cmd_arg_d;
      acc     <= acc_d;
      p       <= p_d;
      m       <= m_d;
      q       <= q_d;
      done    <= done_d;
      err     <= err_d;
      alu_a   <= alu_a_d;
      alu_b   <= alu_b_d;
      alu_op  <= alu_op_d;
    end
  end

  always_comb begin
    state_d   = state;
    cmd_op_d  = cmd_op;
    cmd_arg_d = cmd_arg;
    acc_d     = acc;
    p_d       = p;
    m_d       = m;
    q_d       = q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    alu_a_d   = '0;
    alu_b_d   = '0;
    alu_op_d  = OP_ADD;

    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          cmd_op_d  = head.op[2:0];
          cmd_arg_d = head.arg;
          if (!head.op[3])          state_d = S_EXEC;
          else if (head.op == 4'd8) state_d = S_LOAD;
          else if (head.op == 4'd9) begin
            state_d = S_M_CHK;
            p_d     = '0;
            m_d     = acc;
            q_d     = head.arg;
          end else                  state_d = S_ILL;
        end
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        acc_d   = alu_y;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_LOAD: begin
        acc_d   = cmd_arg;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ILL: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      S_M_CHK: begin
        if (q == 8'd0) begin
          acc_d   = p;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (q[0]) state_d = S_M_ADD;
        else               state_d = S_M_SHL;
      end
      S_M_ADD:   state_d = S_M_ADDWB;
      S_M_ADDWB: begin
        p_d     = alu_y;
        state_d = S_M_SHL;
      end
      S_M_SHL:   state_d = S_M_SHLWB;
      S_M_SHLWB: begin
        m_d     = alu_y;
        q_d     = q >> 1;
        state_d = S_M_CHK;
      end
      default: state_d = S_IDLE;
    endcase

    // ALU ports are registered, so decode them from the state being entered.
    unique case (state_d)
      S_EXEC: begin
        alu_a_d  = acc;
        alu_b_d  = cmd_arg_d;
        alu_op_d = cmd_op_d;
      end
      S_M_ADD: begin
        alu_a_d  = p_d;
        alu_b_d  = m_d;
        alu_op_d = OP_ADD;
      end
      S_M_SHL: begin
        alu_a_d  = m_d;
        alu_b_d  = 8'd1;
        alu_op_d = OP_SLL;
      end
      default: ;
    endcase
  end

  assign zero = (acc == 8'd0);
  assign busy = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural registered ALU attached.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [7:0] in_operand;
  logic [7:0] alu_a, alu_b, alu_y, acc;
  logic [2:0] alu_op;
  logic       zero, busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_operand(in_operand),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .acc(acc), .zero(zero), .busy(busy), .done(done), .err(err)
  );

  // External ALU: one-cycle registered result, shared reset.
  always_ff @(posedge clk) begin
    if (!rst_n) alu_y <= '0;
    else begin
      case (alu_op)
        3'b000: alu_y <= alu_a + alu_b;
        3'b001: alu_y <= alu_a - alu_b;
        3'b010: alu_y <= alu_a << alu_b[2:0];
        3'b011: alu_y <= alu_a >> alu_b[2:0];
        3'b100: alu_y <= alu_a & alu_b;
        3'b101: alu_y <= alu_a | alu_b;
        3'b110: alu_y <= ~(alu_a | alu_b);
        default: alu_y <= alu_a ^ alu_b;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Push one command into an idle sequencer; lat counts cycles from the pop cycle to done.
  task automatic run_cmd(input logic [3:0] op, input logic [7:0] arg,
                         output int lat, output logic [7:0] a, output logic e, output logic z);
    int k;
    @(negedge clk);
    in_valid = 1'b1; in_opcode = op; in_operand = arg;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin @(negedge clk); lat++; end
    a = acc; e = err; z = zero;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] arg;
    logic [7:0] exp_acc;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[21];

  initial begin
    int lat;
    logic [7:0] a;
    logic e, z;
    logic [7:0] got[$];
    logic saw_full;
    int ndone;

    vecs[0]  = '{4'h8, 8'h3C, 8'h3C, 1'b0, 2};
    vecs[1]  = '{4'h0, 8'h05, 8'h41, 1'b0, 3};
    vecs[2]  = '{4'h8, 8'h10, 8'h10, 1'b0, 2};
    vecs[3]  = '{4'h1, 8'h11, 8'hFF, 1'b0, 3};
    vecs[4]  = '{4'h3, 8'h03, 8'h1F, 1'b0, 3};
    vecs[5]  = '{4'h7, 8'h1F, 8'h00, 1'b0, 3};
    vecs[6]  = '{4'h8, 8'h03, 8'h03, 1'b0, 2};
    vecs[7]  = '{4'h9, 8'h05, 8'h0F, 1'b0, 15};
    vecs[8]  = '{4'h8, 8'h20, 8'h20, 1'b0, 2};
    vecs[9]  = '{4'h9, 8'h10, 8'h00, 1'b0, 19};
    vecs[10] = '{4'h9, 8'h00, 8'h00, 1'b0, 2};
    vecs[11] = '{4'h8, 8'h07, 8'h07, 1'b0, 2};
    vecs[12] = '{4'h2, 8'h04, 8'h70, 1'b0, 3};
    vecs[13] = '{4'h4, 8'h3F, 8'h30, 1'b0, 3};
    vecs[14] = '{4'h5, 8'h05, 8'h35, 1'b0, 3};
    vecs[15] = '{4'h6, 8'h0F, 8'hC0, 1'b0, 3};
    vecs[16] = '{4'hC, 8'h55, 8'hC0, 1'b1, 2};
    vecs[17] = '{4'h0, 8'h01, 8'hC1, 1'b0, 3};
    vecs[18] = '{4'h8, 8'h0B, 8'h0B, 1'b0, 2};
    vecs[19] = '{4'h9, 8'h0D, 8'h8F, 1'b0, 20};
    vecs[20] = '{4'h9, 8'hFF, 8'h71, 1'b0, 42};

    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_operand = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_zero",     32'(zero),     32'd1);
    check("rst_acc",      32'(acc),      32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_alu",      {13'd0, alu_a, alu_b, alu_op}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      run_cmd(vecs[i].op, vecs[i].arg, lat, a, e, z);
      check($sformatf("v%0d_lat", i),  32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_acc", i),  32'(a),   32'(vecs[i].exp_acc));
      check($sformatf("v%0d_err", i),  32'(e),   32'(vecs[i].exp_err));
      check($sformatf("v%0d_zero", i), 32'(z),   32'(vecs[i].exp_acc == 8'd0));
      @(negedge clk);
      check($sformatf("v%0d_pulse", i), {30'd0, done, err}, 32'd0);
    end

    // Burst: seven ADDs pushed back to back behind a LOAD 0 must retire in order.
    run_cmd(4'h8, 8'h00, lat, a, e, z);
    saw_full = 1'b0;
    ndone = 0;
    fork
      begin
        for (int i = 1; i <= 7; i++) begin
          int k;
          @(negedge clk);
          in_valid = 1'b1; in_opcode = 4'h0; in_operand = 8'(i);
          k = 0;
          while (!in_ready && k < 50) begin saw_full = 1'b1; @(negedge clk); k++; end
          @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 200 && ndone < 7; c++) begin
          @(negedge clk);
          if (done) begin got.push_back(acc); ndone++; end
        end
      end
    join
    check("burst_count", 32'(ndone), 32'd7);
    check("burst_full_seen", 32'(saw_full), 32'd1);
    begin
      logic [7:0] run_sum;
      run_sum = 8'd0;
      for (int i = 1; i <= 7; i++) begin
        run_sum = run_sum + 8'(i);
        check($sformatf("burst_acc%0d", i), (i <= got.size()) ? 32'(got[i-1]) : 32'hDEAD,
              32'(run_sum));
      end
    end
    repeat (3) @(negedge clk);
    check("burst_idle", 32'(busy), 32'd0);

    // Reset in the middle of a multiply with two commands still queued.
    run_cmd(4'h8, 8'h03, lat, a, e, z);
    @(negedge clk);
    in_valid = 1'b1; in_opcode = 4'h9; in_operand = 8'h0F;
    @(negedge clk);
    in_opcode = 4'h8; in_operand = 8'h01;
    @(negedge clk);
    in_opcode = 4'h8; in_operand = 8'h02;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_mul_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mreset_acc",   32'(acc),      32'd0);
    check("mreset_busy",  32'(busy),     32'd0);
    check("mreset_ready", 32'(in_ready), 32'd1);
    check("mreset_done",  {30'd0, done, err}, 32'd0);
    check("mreset_alu",   {13'd0, alu_a, alu_b, alu_op}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("mreset_quiet", 32'(ndone), 32'd0);
    check("mreset_acc_hold", 32'(acc), 32'd0);
    run_cmd(4'h8, 8'h5A, lat, a, e, z);
    check("post_reset_load", {24'(lat), a}, {24'd2, 8'h5A});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
